// File: rtl/output_port_tx.sv
// output_port_tx
//   Transmit side of a router output port. Arbitrates among the input ports'
//   new-flit requests, locks onto the winning input for a whole wormhole
//   packet (head to tail), and forwards each flit through a one-entry output
//   register onto a valid/ready link. The input whose flit is captured gets a
//   one-cycle grant so it can pop.
//
//   Configuration macro: ROUND_ROBIN_EN
//     defined   : IDLE arbitration is round-robin from a rotating pointer
//     undefined : fixed priority, lowest port index wins
//
//   Ports
//     clk       in   clock, rising edge
//     rst_n     in   synchronous active-low reset
//     req       in   [PORTS]        per-port new-flit request
//     flit_in   in   [PORTS*FLIT_W] port 0 in the most significant FLIT_W bits
//     grant     out  [PORTS]        one-hot pop pulse for the captured port
//     tx_valid  out                 output register holds a flit
//     tx_flit   out  [FLIT_W]       flit to downstream
//     tx_ready  in                  downstream accepts tx_flit this edge
//     locked    out                 a packet is in progress
//     cur_port  out  [3]            locked port, 0 when unlocked
//     err       out                 sticky protocol-error flag
//
//   Flit type lives in the two most significant bits of each flit:
//   10 head, 00 body, 01 tail, 11 single.

`ifndef FLIT_SIZE
`define FLIT_SIZE 16
`endif

module output_port_tx #(
  parameter int unsigned PORTS  = 5,
  parameter int unsigned FLIT_W = `FLIT_SIZE
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PORTS-1:0]          req,
  input  logic [PORTS*FLIT_W-1:0]   flit_in,
  output logic [PORTS-1:0]          grant,
  output logic                      tx_valid,
  output logic [FLIT_W-1:0]         tx_flit,
  input  logic                      tx_ready,
  output logic                      locked,
  output logic [2:0]                cur_port,
  output logic                      err
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t            state_q;
  logic              tx_valid_q;
  logic [FLIT_W-1:0] tx_flit_q;
  logic [2:0]        cur_port_q;
  logic              err_q;

  logic [FLIT_W-1:0] flit [PORTS];
  logic [PORTS-1:0]  is_start;   // head or single
  logic [PORTS-1:0]  cand;
  logic              bad_idle;
  logic              win_vld;
  logic [2:0]        win_idx;
  logic [FLIT_W-1:0] win_flit;
  logic              cap;

  // Ascending-numbered concatenation: port 0 sits in the top bits.
  always_comb begin
    for (int unsigned i = 0; i < PORTS; i++) begin
      flit[i]     = flit_in[(PORTS-i)*FLIT_W-1 -: FLIT_W];
      is_start[i] = flit[i][FLIT_W-1];
    end
  end

  always_comb begin
    cand     = '0;
    bad_idle = 1'b0;
    if (state_q == IDLE) begin
      cand     = req & is_start;
      bad_idle = |(req & ~is_start);
    end else begin
      cand[cur_port_q] = req[cur_port_q];
    end
  end

`ifdef ROUND_ROBIN_EN
  logic [2:0]  rr_ptr_q;
  int unsigned rr_idx;

  // In LOCK only cur_port can be a candidate, so the pointer is irrelevant there.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    rr_idx  = 0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      rr_idx = (32'(rr_ptr_q) + k) % PORTS;
      if (!win_vld && cand[rr_idx]) begin
        win_vld = 1'b1;
        win_idx = 3'(rr_idx);
      end
    end
  end
`else
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      if (!win_vld && cand[k]) begin
        win_vld = 1'b1;
        win_idx = 3'(k);
      end
    end
  end
`endif

  always_comb begin
    win_flit = flit[win_idx];
    cap      = rst_n & win_vld & (~tx_valid_q | tx_ready);
    grant    = '0;
    if (cap) grant[win_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_valid_q <= 1'b0;
      tx_flit_q  <= '0;
      cur_port_q <= '0;
      err_q      <= 1'b0;
`ifdef ROUND_ROBIN_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      if (bad_idle) err_q <= 1'b1;
      if (cap) begin
        tx_flit_q  <= win_flit;
        tx_valid_q <= 1'b1;
`ifdef ROUND_ROBIN_EN
        if (win_flit[FLIT_W-1])
          rr_ptr_q <= (win_idx == 3'(PORTS-1)) ? '0 : win_idx + 3'd1;
`endif
        if (state_q == IDLE) begin
          if (!win_flit[FLIT_W-2]) begin
            state_q    <= LOCK;
            cur_port_q <= win_idx;
          end
        end else if (win_flit[FLIT_W-1]) begin
          // Head/single inside a packet: forward it, flag, and drop the lock.
          err_q      <= 1'b1;
          state_q    <= IDLE;
          cur_port_q <= '0;
        end else if (win_flit[FLIT_W-2]) begin
          state_q    <= IDLE;
          cur_port_q <= '0;
        end
      end else if (tx_valid_q && tx_ready) begin
        tx_valid_q <= 1'b0;
      end
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_flit  = tx_flit_q;
  assign locked   = (state_q == LOCK);
  assign cur_port = cur_port_q;
  assign err      = err_q;

endmodule

// File: tb/tb_output_port_tx.sv
// Directed bench for output_port_tx with 5 ports and 16-bit flits.
// Flit type is the top two bits: 8xxx head, 0xxx body, 4xxx tail, Cxxx single.

module tb_output_port_tx;

  localparam int unsigned PORTS = 5;
  localparam int unsigned W     = 16;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [PORTS-1:0]       req;
  logic [PORTS*W-1:0]     flit_in;
  logic [PORTS-1:0]       grant;
  logic                   tx_valid;
  logic [W-1:0]           tx_flit;
  logic                   tx_ready;
  logic                   locked;
  logic [2:0]             cur_port;
  logic                   err;

  always #5 clk = ~clk;

  output_port_tx #(.PORTS(PORTS), .FLIT_W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .flit_in  (flit_in),
    .grant    (grant),
    .tx_valid (tx_valid),
    .tx_flit  (tx_flit),
    .tx_ready (tx_ready),
    .locked   (locked),
    .cur_port (cur_port),
    .err      (err)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int unsigned p, input logic [W-1:0] f, input logic r);
    flit_in[(PORTS-p)*W-1 -: W] = f;
    req[p] = r;
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    flit_in  = '0;
    tx_ready = 1'b1;

    // Reset: no grant even with a pending request
    set_port(2, 16'hC0A5, 1'b1);
    #1 check("grant_in_reset", 32'(grant), 32'h0);
    tick;
    tick;
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_tx_flit", 32'(tx_flit), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_cur_port", 32'(cur_port), 32'h0);
    check("rst_err", 32'(err), 32'h0);

    // Single flit from port 2, then a second back-to-back single
    rst_n = 1'b1;
    #1 check("single_grant", 32'(grant), 32'h04);
    tick;
    set_port(2, 16'hC0A6, 1'b1);
    #1;
    check("single_tx_valid", 32'(tx_valid), 32'h1);
    check("single_tx_flit", 32'(tx_flit), 32'hC0A5);
    check("single_locked", 32'(locked), 32'h0);
    check("b2b_grant", 32'(grant), 32'h04);
    tick;
    set_port(2, 16'h0, 1'b0);
    #1;
    check("b2b_tx_flit", 32'(tx_flit), 32'hC0A6);
    check("b2b_tx_valid", 32'(tx_valid), 32'h1);
    check("idle_grant", 32'(grant), 32'h0);
    tick;
    check("drain_tx_valid", 32'(tx_valid), 32'h0);

    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;

    // Ports 1 and 3 both present heads; port 1 wins and holds the lock
    set_port(1, 16'h8011, 1'b1);
    set_port(3, 16'h8033, 1'b1);
    #1 check("arb_grant", 32'(grant), 32'h02);
    tick;
    set_port(1, 16'h0012, 1'b1);
    #1;
    check("arb_cur_port", 32'(cur_port), 32'h1);
    check("arb_locked", 32'(locked), 32'h1);
    check("arb_tx_flit", 32'(tx_flit), 32'h8011);
    check("body_grant", 32'(grant), 32'h02);
    tick;
    set_port(1, 16'h4013, 1'b1);
    #1;
    check("body_tx_flit", 32'(tx_flit), 32'h0012);
    check("tail_grant", 32'(grant), 32'h02);
    check("body_locked", 32'(locked), 32'h1);
    tick;
    set_port(1, 16'h0, 1'b0);
    #1;
    check("tail_tx_flit", 32'(tx_flit), 32'h4013);
    check("tail_locked", 32'(locked), 32'h0);
    check("tail_cur_port", 32'(cur_port), 32'h0);
    check("p3_grant", 32'(grant), 32'h08);
    tick;

    // Stall mid-packet on port 3
    set_port(3, 16'h0034, 1'b1);
    tx_ready = 1'b0;
    #1;
    check("p3_cur_port", 32'(cur_port), 32'h3);
    check("stall_grant0", 32'(grant), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick;
      check("stall_tx_flit", 32'(tx_flit), 32'h8033);
      check("stall_tx_valid", 32'(tx_valid), 32'h1);
      check("stall_locked", 32'(locked), 32'h1);
      check("stall_grant", 32'(grant), 32'h0);
    end
    tx_ready = 1'b1;
    #1 check("release_grant", 32'(grant), 32'h08);
    tick;
    set_port(3, 16'h4035, 1'b1);
    #1;
    check("release_tx_flit", 32'(tx_flit), 32'h0034);
    check("p3_tail_grant", 32'(grant), 32'h08);
    tick;
    set_port(3, 16'h0, 1'b0);
    #1;
    check("p3_tail_tx_flit", 32'(tx_flit), 32'h4035);
    check("p3_tail_locked", 32'(locked), 32'h0);
    tick;
    check("p3_drain", 32'(tx_valid), 32'h0);

    // Body flit in IDLE: never granted, sticky error
    set_port(0, 16'h0001, 1'b1);
    #1;
    check("bad_grant0", 32'(grant), 32'h0);
    check("bad_err0", 32'(err), 32'h0);
    tick;
    check("bad_err1", 32'(err), 32'h1);
    check("bad_grant1", 32'(grant), 32'h0);
    check("bad_tx_valid", 32'(tx_valid), 32'h0);
    tick;
    check("bad_grant2", 32'(grant), 32'h0);
    set_port(0, 16'h0, 1'b0);
    tick;
    check("err_sticky", 32'(err), 32'h1);

    // Lock to port 4 with a held flit, then reset
    set_port(4, 16'h8044, 1'b1);
    #1 check("p4_grant", 32'(grant), 32'h10);
    tick;
    set_port(4, 16'h0, 1'b0);
    #1;
    check("p4_locked", 32'(locked), 32'h1);
    check("p4_cur_port", 32'(cur_port), 32'h4);
    check("p4_tx_valid", 32'(tx_valid), 32'h1);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("mid_rst_tx_valid", 32'(tx_valid), 32'h0);
    check("mid_rst_tx_flit", 32'(tx_flit), 32'h0);
    check("mid_rst_locked", 32'(locked), 32'h0);
    check("mid_rst_cur_port", 32'(cur_port), 32'h0);
    check("mid_rst_err", 32'(err), 32'h0);
    check("mid_rst_grant", 32'(grant), 32'h0);

    // Head arriving inside a packet: captured, error, back to IDLE
    set_port(0, 16'h8001, 1'b1);
    #1 check("lk_head_grant", 32'(grant), 32'h01);
    tick;
    set_port(0, 16'h8002, 1'b1);
    #1;
    check("lk_locked", 32'(locked), 32'h1);
    check("lk_err0", 32'(err), 32'h0);
    check("lk_bad_grant", 32'(grant), 32'h01);
    tick;
    set_port(0, 16'h0, 1'b0);
    #1;
    check("lk_bad_tx_flit", 32'(tx_flit), 32'h8002);
    check("lk_bad_locked", 32'(locked), 32'h0);
    check("lk_bad_err", 32'(err), 32'h1);
    tick;

`ifdef ROUND_ROBIN_EN
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    set_port(0, 16'hC000, 1'b1);
    set_port(1, 16'hC001, 1'b1);
    #1;
    for (int k = 0; k < 4; k++) begin
      check("rr_grant", 32'(grant), (k % 2 == 0) ? 32'h01 : 32'h02);
      tick;
    end
    set_port(0, 16'h0, 1'b0);
    set_port(1, 16'h0, 1'b0);
    tick;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/output_port_tx.md
# output_port_tx

Transmit side of a router output port. Takes the per-input-port request (`isNew`) and flit lines that the priority chain resolves, picks one input, and locks onto it for a whole wormhole packet (head to tail). Each flit goes through a one-entry output register and a valid/ready link to the downstream router. The block returns a one-cycle grant (pop) to the input port whose flit was captured.

## Interface
Parameters:
- `PORTS`, 5: number of input ports competing for this output; port index width is 3 bits.
- `FLIT_W`, `` `FLIT_SIZE ``: flit width, from `constants.v`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req`  in  PORTS  bit i high: input port i presents a new flit for this output (its `isNew`).
- `flit_in`  in  PORTS*FLIT_W  concatenated flits; port i occupies bits `[i*FLIT_W : (i+1)*FLIT_W-1]`.
- `grant`  out  PORTS  one-hot pulse; bit i high: port i's flit captured this edge, port i must pop.
- `tx_valid`  out  1  output register holds a flit.
- `tx_flit`  out  FLIT_W  flit to downstream, `[1:FLIT_W]`.
- `tx_ready`  in  1  downstream accepts `tx_flit` at this edge when `tx_valid`.
- `locked`  out  1  a packet is in progress.
- `cur_port`  out  3  port currently locked; 0 when unlocked.
- `err`  out  1  sticky protocol-error flag.

## Operation
- The flit type is in bits `[1:2]` of each flit: 10 head, 00 body, 01 tail, 11 single (head and tail).
- FSM has two states.
  - IDLE: candidates are ports with `req` high and type head or single.
  - LOCK: the only candidate is `cur_port`, and only if its `req` is high.
- Winner selection in IDLE: with fixed priority (default), the lowest-index candidate wins. This matches the priority chain, where an earlier `isNew` overrides later ones.
- Capture condition: `cap = winner_exists & (!tx_valid | tx_ready)`.
- On `cap`:
  - `tx_flit` <= winner flit, `tx_valid` <= 1.
  - `grant[winner]` = 1 for that cycle. `grant` is combinational from the registered state and inputs, and is asserted in the same cycle as the capturing edge.
- State transitions:
  - IDLE -> LOCK when a head flit is captured; `cur_port` <= winner.
  - IDLE -> IDLE when a single flit is captured.
  - LOCK -> IDLE when a tail flit is captured; `cur_port` <= 0.
- On `tx_valid & tx_ready & !cap`: `tx_valid` <= 0.
- Protocol errors set `err` to 1, and it stays set until reset:
  - IDLE with `req[i]` high and type body or tail. The flit is ignored and never granted.
  - LOCK with `req[cur_port]` high and type head or single. The flit is captured anyway and the FSM returns to IDLE.
- In LOCK, requests from other ports are never granted.

## Timing
- Reset values: `tx_valid`=0, `tx_flit`=0, `grant`=0, `locked`=0, `cur_port`=0, `err`=0, state IDLE. Round-robin pointer = 0.
- Reset asserted mid-packet discards the lock and any held flit at the next edge. No grant is issued while `rst_n`=0.
- Latency: a request sampled at edge N with the register free gives `tx_valid`=1 after edge N.
- Throughput is one flit per cycle while `tx_ready` stays high. The register refills on the same edge it drains, so there is no bubble.
- When `tx_ready`=0 and `tx_valid`=1:
  - `tx_flit` is held stable.
  - No capture and no grant.
  - The lock is held.
- `tx_flit` and `tx_valid` never change while `tx_valid & !tx_ready`.

## Configuration
- `ROUND_ROBIN_EN` defined:
  - IDLE winner is the first candidate at or after `rr_ptr`, with wrap-around modulo `PORTS`.
  - On each capture of a head or single flit, `rr_ptr` <= winner+1, wrapping to 0 after `PORTS-1`.
- Not defined: fixed lowest-index priority and no pointer register.

## Test plan
- Port 2 sends single flit 0xA5 (type 11) with `tx_ready`=1 -> `grant`=00100 for one cycle, `tx_valid`=1 next cycle with `tx_flit`=that flit, state stays IDLE.
- Ports 1 and 3 both send heads:
  - Fixed priority -> port 1 granted, `cur_port`=1.
  - Port 1 body then tail follow -> port 3 not granted until the cycle after the tail is captured.
- `tx_ready`=0 for 4 cycles mid-packet -> `tx_flit` stable, `grant`=0, `locked`=1; once `tx_ready` goes high, the next flit is captured on that same edge.
- Port 0 presents a body flit in IDLE -> never granted, `err`=1, and it stays 1 until `rst_n`=0.
- `rst_n`=0 for one cycle while locked to port 4 with `tx_valid`=1 -> all outputs return to reset values on the next edge.
- With `ROUND_ROBIN_EN`: ports 0 and 1 send back-to-back single flits continuously -> grants alternate 0,1,0,1.
